// File: rtl/gesture_pkg.sv
// rtl/gesture_pkg.sv - shared mode, state and frame-geometry definitions
package gesture_pkg;

  // Per-pixel classification mode carried down the pipeline with each pixel
  typedef enum logic [1:0] {
    MODE_SKIN   = 2'b00,
    MODE_BGDIFF = 2'b01,
    MODE_AND    = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;

  // Background capture controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARM   = 2'b01,
    ST_CAPT  = 2'b10,
    ST_READY = 2'b11
  } state_e;

  localparam int FRAME_W           = 160;
  localparam int FRAME_H           = 120;
  localparam int FRAME_PIX_DEFAULT = FRAME_W * FRAME_H;

endpackage

// File: rtl/bg_frame_ram.sv
// rtl/bg_frame_ram.sv - single-port background luma frame store, 1-cycle write-first read
module bg_frame_ram #(
  parameter int DEPTH  = 19200,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Enabled access: write stores the word and forwards it to the read port
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/skin_bg_classifier.sv
// rtl/skin_bg_classifier.sv - per-pixel skin / background-difference object mask
module skin_bg_classifier
  import gesture_pkg::*;
#(
  parameter int              DATA_W    = 8,
  parameter int              FRAME_PIX = FRAME_PIX_DEFAULT,
  parameter int              ADDR_W    = 15,
  parameter logic [DATA_W:0]   DIFF_TH = 9'd120,
  parameter logic [DATA_W-1:0] Y_MIN   = 8'd80,
  parameter logic [DATA_W-1:0] CB_MIN  = 8'd125,
  parameter logic [DATA_W-1:0] CB_MAX  = 8'd180,
  parameter logic [DATA_W-1:0] CR_MIN  = 8'd190,
  parameter logic [DATA_W-1:0] CR_MAX  = 8'd225
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [DATA_W-1:0] luma_ch,
  input  logic [DATA_W-1:0] cb_ch,
  input  logic [DATA_W-1:0] cr_ch,
  input  logic [1:0]        mode,
  input  logic              capture_req,
  output logic              obj_valid,
  output logic              object_image,
  output logic              bg_ready,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_FULL = ADDR_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIX - 1);

  state_e            state;
  logic [ADDR_W-1:0] addr;

  logic              sof_v;
  logic              in_range;
  logic [ADDR_W-1:0] cur_addr;
  logic              cap_start;
  logic              ram_we;
  logic              ram_en;
  logic              skin_hit;
  logic              bg_usable;

  // A sof pixel always takes address 0; past a full frame the pixel has no slot
  assign sof_v     = pix_valid & pix_sof;
  assign in_range  = sof_v | (addr != ADDR_FULL);
  assign cur_addr  = sof_v ? '0 : addr;
  assign cap_start = sof_v & ((state == ST_ARM) |
                              (capture_req & ((state == ST_IDLE) | (state == ST_READY))));
  assign ram_we    = cap_start | (pix_valid & ~pix_sof & (state == ST_CAPT));
  assign ram_en    = pix_valid & in_range;

  assign skin_hit  = (luma_ch > Y_MIN) &
                     (cb_ch > CB_MIN) & (cb_ch < CB_MAX) &
                     (cr_ch > CR_MIN) & (cr_ch < CR_MAX);
  // A pixel that starts a new capture belongs to the capture, not the old background
  assign bg_usable = bg_ready & ~capture_req & in_range;

  // Capture controller, pixel address counter and sticky frame error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      addr      <= '0;
      bg_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (capture_req) frame_err <= 1'b0;
      if (pix_valid) begin
        if (pix_sof) begin
          addr <= ADDR_W'(1);
          if ((addr != '0) && (addr != ADDR_FULL)) frame_err <= 1'b1;
        end else if (addr == ADDR_FULL) begin
          frame_err <= 1'b1;
        end else begin
          addr <= addr + ADDR_W'(1);
        end
      end
      case (state)
        ST_IDLE: begin
          if (capture_req) state <= cap_start ? ST_CAPT : ST_ARM;
        end
        ST_ARM: begin
          if (cap_start) state <= ST_CAPT;
        end
        ST_CAPT: begin
          if (pix_valid) begin
            if (pix_sof) begin
              state     <= ST_IDLE;
              frame_err <= 1'b1;
            end else if (addr == ADDR_LAST) begin
              state    <= ST_READY;
              bg_ready <= 1'b1;
            end
          end
        end
        ST_READY: begin
          if (capture_req) begin
            bg_ready <= 1'b0;
            state    <= cap_start ? ST_CAPT : ST_ARM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic [DATA_W-1:0] bg_rd;

  bg_frame_ram #(
    .DEPTH  (FRAME_PIX),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_bg_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (cur_addr),
    .wdata (luma_ch),
    .rdata (bg_rd)
  );

  logic              v1;
  mode_e             mode1;
  logic              skin1;
  logic              bgok1;
  logic [DATA_W-1:0] y1;

  // Stage 1: hold pixel attributes alongside the RAM read in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      mode1 <= MODE_SKIN;
      skin1 <= 1'b0;
      bgok1 <= 1'b0;
      y1    <= '0;
    end else begin
      v1    <= pix_valid;
      mode1 <= mode_e'(mode);
      skin1 <= skin_hit;
      bgok1 <= bg_usable;
      y1    <= luma_ch;
    end
  end

  logic [DATA_W:0] diff;
  logic            bg_hit;
  logic            obj_next;

  assign diff   = (y1 >= bg_rd) ? ({1'b0, y1} - {1'b0, bg_rd})
                                : ({1'b0, bg_rd} - {1'b0, y1});
  assign bg_hit = bgok1 & (diff > DIFF_TH);

  // Mode select for the pixel leaving stage 1
  always_comb begin
    obj_next = 1'b0;
    case (mode1)
      MODE_SKIN:   obj_next = skin1;
      MODE_BGDIFF: obj_next = bg_hit;
      MODE_AND:    obj_next = skin1 & bg_hit;
      default:     obj_next = 1'b0;
    endcase
  end

  // Stage 2: registered mask output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obj_valid    <= 1'b0;
      object_image <= 1'b0;
    end else begin
      obj_valid    <= v1;
      object_image <= v1 & obj_next;
    end
  end

endmodule

// File: tb/tb_skin_bg_classifier.sv
// tb/tb_skin_bg_classifier.sv - scoreboard bench for skin_bg_classifier
module tb_skin_bg_classifier;
  import gesture_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic       pix_sof = 1'b0;
  logic [7:0] luma_ch = '0;
  logic [7:0] cb_ch = '0;
  logic [7:0] cr_ch = '0;
  logic [1:0] mode = '0;
  logic       capture_req = 1'b0;
  logic       obj_valid;
  logic       object_image;
  logic       bg_ready;
  logic       frame_err;

  int n_run  = 0;
  int n_fail = 0;
  int n_out  = 0;
  bit exp_q[$];
  bit gap_chk = 1'b0;
  logic pv_h1 = 1'b0;
  logic pv_h2 = 1'b0;

  skin_bg_classifier dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid    (pix_valid),
    .pix_sof      (pix_sof),
    .luma_ch      (luma_ch),
    .cb_ch        (cb_ch),
    .cr_ch        (cr_ch),
    .mode         (mode),
    .capture_req  (capture_req),
    .obj_valid    (obj_valid),
    .object_image (object_image),
    .bg_ready     (bg_ready),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit ref_obj(input logic [1:0] m, input logic [7:0] y, input logic [7:0] cb,
                                 input logic [7:0] cr, input int bg, input bit bgok);
    bit skin;
    int d;
    bit bh;
    skin = (y > 80) && (cb > 125) && (cb < 180) && (cr > 190) && (cr < 225);
    d    = (int'(y) > bg) ? int'(y) - bg : bg - int'(y);
    bh   = bgok && (d > 120);
    case (m)
      2'd0:    return skin;
      2'd1:    return bh;
      2'd2:    return skin && bh;
      default: return 1'b0;
    endcase
  endfunction

  task automatic px(input bit sof, input bit cap, input logic [1:0] m, input logic [7:0] y,
                    input logic [7:0] cb, input logic [7:0] cr, input bit e);
    pix_valid   = 1'b1;
    pix_sof     = sof;
    capture_req = cap;
    mode        = m;
    luma_ch     = y;
    cb_ch       = cb;
    cr_ch       = cr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pix_valid   = 1'b0;
    pix_sof     = 1'b0;
    capture_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cap_pulse();
    capture_req = 1'b1;
    @(posedge clk);
    #1;
    capture_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
  endtask

  // Monitor: pop expected mask bits and check obj_valid tracks pix_valid two cycles back
  always @(negedge clk) begin
    if (!rst) begin
      if (gap_chk) chk("valid_delay2", obj_valid, pv_h2);
      if (obj_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_obj_valid", 1, 0);
        end else begin
          chk($sformatf("pixel_%0d", n_out), object_image, exp_q.pop_front());
        end
        n_out++;
      end
    end
    pv_h2 = pv_h1;
    pv_h1 = pix_valid;
  end

  initial begin
    logic [1:0] m;
    logic [7:0] y, cb, cr;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_obj_valid", obj_valid, 0);
    chk("rst_object_image", object_image, 0);
    chk("rst_bg_ready", bg_ready, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_state", dut.state, ST_IDLE);
    rst = 1'b0;
    idle(1);

    // Skin window edges
    px(1, 0, 2'd0, 8'd81, 8'd126, 8'd191, 1);
    px(0, 0, 2'd0, 8'd80, 8'd126, 8'd191, 0);
    px(0, 0, 2'd0, 8'd81, 8'd180, 8'd200, 0);
    px(0, 0, 2'd0, 8'd81, 8'd150, 8'd225, 0);
    idle(4);

    // Background capture of a flat Y=50 frame, then one pixel too many
    do_reset();
    cap_pulse();
    chk("arm_state", dut.state, ST_ARM);
    for (int i = 0; i < 19200; i++) begin
      px(i == 0, 0, 2'd1, 8'd50, 8'd0, 8'd0, 0);
      if (i == 19198) chk("bg_ready_before_last", bg_ready, 0);
    end
    chk("bg_ready_after_last", bg_ready, 1);
    chk("frame_err_full_frame", frame_err, 0);
    px(0, 0, 2'd0, 8'd50, 8'd0, 8'd0, 0);
    chk("frame_err_19201", frame_err, 1);

    // Background difference threshold and no-wrap
    px(1, 0, 2'd1, 8'd171, 8'd0, 8'd0, 1);
    px(0, 0, 2'd1, 8'd170, 8'd0, 8'd0, 0);
    px(0, 0, 2'd1, 8'd0,   8'd0, 8'd0, 0);
    // Combined mode, reserved mode, skin mode with background present
    px(0, 0, 2'd2, 8'd200, 8'd150, 8'd200, 1);
    px(0, 0, 2'd2, 8'd200, 8'd150, 8'd230, 0);
    px(0, 0, 2'd2, 8'd200, 8'd100, 8'd200, 0);
    px(0, 0, 2'd3, 8'd200, 8'd150, 8'd200, 0);
    px(0, 0, 2'd0, 8'd200, 8'd150, 8'd200, 1);

    // Random pixel gaps against the reference model
    gap_chk = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(1) == 1) begin
        m  = 2'($urandom_range(3));
        y  = 8'($urandom_range(255));
        cb = 8'($urandom_range(185, 120));
        cr = 8'($urandom_range(230, 185));
        px(0, 0, m, y, cb, cr, ref_obj(m, y, cb, cr, 50, 1'b1));
      end else begin
        idle(1);
      end
    end
    idle(4);
    gap_chk = 1'b0;

    // Capture cut short by an early sof
    do_reset();
    cap_pulse();
    for (int i = 0; i < 100; i++) px(i == 0, 0, 2'd1, 8'd50, 8'd0, 8'd0, 0);
    px(1, 0, 2'd1, 8'd200, 8'd0, 8'd0, 0);
    chk("trunc_frame_err", frame_err, 1);
    chk("trunc_bg_ready", bg_ready, 0);
    chk("trunc_state", dut.state, ST_IDLE);
    idle(4);

    // Reset in the middle of a capture; skin mode keeps working while capturing
    do_reset();
    cap_pulse();
    for (int i = 0; i < 50; i++) px(i == 0, 0, 2'd0, 8'd81, 8'd126, 8'd191, 1);
    chk("mid_capt_state", dut.state, ST_CAPT);
    chk("pre_rst_obj_valid", obj_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_obj_valid", obj_valid, 0);
    chk("rst_mid_bg_ready", bg_ready, 0);
    chk("rst_mid_state", dut.state, ST_IDLE);
    exp_q.delete();
    idle(2);
    rst = 1'b0;

    // capture_req coincident with sof: the sof pixel (Y=250) lands at address 0
    px(1, 1, 2'd1, 8'd250, 8'd0, 8'd0, 0);
    for (int i = 1; i < 19200; i++) px(0, 0, 2'd1, 8'd50, 8'd0, 8'd0, 0);
    idle(2);
    chk("same_cycle_bg_ready", bg_ready, 1);
    chk("same_cycle_frame_err", frame_err, 0);
    px(1, 0, 2'd1, 8'd0,   8'd0, 8'd0, 1);
    px(0, 0, 2'd1, 8'd0,   8'd0, 8'd0, 0);
    px(0, 0, 2'd1, 8'd171, 8'd0, 8'd0, 1);
    idle(5);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
